// File: rtl/sample_ring_writer.sv
// sample_ring_writer: buffers a 32-bit sample stream and writes it as an Avalon-MM master into a circular word window.
module sample_ring_writer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0,
  parameter int RING_WORDS = 35000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              enable,
  input  logic              clear,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [15:0]       wrap_count,
  output logic              overflow
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + RING_WORDS - 1);
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [IW-1:0]     rd_q, rd_d, wi_q, wi_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [0:0]        state_q, state_d;
  logic              pend_q, pend_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       wrap_q, wrap_d;
  logic              full, push, done, stalled, apply;
  assign full           = cnt_q == CW'(FIFO_DEPTH);
  assign snk_ready      = reset_n & enable & ~full & ~pend_q;
  assign push           = snk_valid & snk_ready;
  assign avm_write      = state_q == WRITE;
  assign done           = avm_write & ~avm_waitrequest;
  assign stalled        = avm_write & avm_waitrequest;
  // A clear seen during a stall waits for that write to finish so the bus transaction is never abandoned.
  assign apply          = (clear & ~stalled) | (pend_q & done);
  assign avm_address    = ptr_q;
  assign avm_writedata  = avm_write ? mem_q[rd_q] : '0;
  assign avm_byteenable = 4'hF;
  assign wr_ptr         = ptr_q;
  assign wrap_count     = wrap_q;
  assign overflow       = ovf_q;
  always_comb begin
    cnt_d   = cnt_q + CW'(push) - CW'(done);
    rd_d    = rd_q + IW'(done);
    wi_d    = wi_q + IW'(push);
    ptr_d   = done ? (ptr_q == LAST ? BASE : ptr_q + 1'b1) : ptr_q;
    wrap_d  = wrap_q + 16'(done && ptr_q == LAST);
    ovf_d   = ovf_q | (enable & snk_valid & ~snk_ready);
    pend_d  = pend_q | (clear & stalled);
    state_d = state_q == IDLE ? (cnt_q != '0 ? WRITE : IDLE) : (done && cnt_d == '0 ? IDLE : WRITE);
    if (apply) begin
      cnt_d   = '0;
      rd_d    = '0;
      wi_d    = '0;
      ptr_d   = BASE;
      wrap_d  = '0;
      ovf_d   = 1'b0;
      pend_d  = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      rd_q    <= '0;
      wi_q    <= '0;
      ptr_q   <= BASE;
      wrap_q  <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wi_q    <= wi_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wi_q] <= snk_data;
  end
endmodule

// File: tb/tb_sample_ring_writer.sv
// tb_sample_ring_writer: directed checks of the ring writer with a 5-word window at base 100.
module tb_sample_ring_writer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready, enable, clear;
  logic [15:0] avm_address, wr_ptr, wrap_count;
  logic        avm_write, avm_waitrequest, overflow;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  int errors = 0;
  int checks = 0;
  sample_ring_writer #(.ADDR_W(16), .FIFO_DEPTH(4), .BASE_ADDR(100), .RING_WORDS(5)) dut (
    .clk(clk), .reset_n(reset_n), .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_ready(snk_ready), .enable(enable), .clear(clear), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .wr_ptr(wr_ptr), .wrap_count(wrap_count),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    snk_data = '0; snk_valid = 0; enable = 1; clear = 0; avm_waitrequest = 0;
    #1 reset_n = 0;
    #1;
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 100);
    chk("rst_data", avm_writedata, 0);
    chk("rst_ptr", wr_ptr, 100);
    chk("rst_wrap", wrap_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", snk_ready, 0);
    tick();
    reset_n = 1;
    // single sample: write appears two cycles after acceptance
    snk_data = 32'hDEADBEEF; snk_valid = 1; #1;
    chk("single_ready", snk_ready, 1);
    tick();
    snk_valid = 0; #1;
    chk("single_c1_write", avm_write, 0);
    tick();
    chk("single_write", avm_write, 1);
    chk("single_addr", avm_address, 100);
    chk("single_data", avm_writedata, 32'hDEADBEEF);
    chk("single_be", avm_byteenable, 4'hF);
    tick();
    chk("single_c3_write", avm_write, 0);
    chk("single_ptr", wr_ptr, 101);
    // idle clear discards a same-cycle push
    clear = 1; snk_valid = 1; snk_data = 32'hBAD; #1;
    tick();
    clear = 0; snk_valid = 0; #1;
    chk("clr_ptr", wr_ptr, 100);
    chk("clr_wrap", wrap_count, 0);
    tick();
    chk("clr_discard", avm_write, 0);
    // 12 back-to-back samples across two wraps
    for (int c = 0; c < 14; c++) begin
      snk_valid = c < 12; snk_data = 32'(c + 1); #1;
      if (c < 12) chk("stream_ready", snk_ready, 1);
      chk("stream_write", avm_write, c >= 2);
      if (c >= 2) begin
        chk("stream_addr", avm_address, 32'(100 + (c - 2) % 5));
        chk("stream_data", avm_writedata, 32'(c - 1));
      end
      chk("stream_ovf", overflow, 0);
      tick();
    end
    snk_valid = 0; #1;
    chk("stream_end_write", avm_write, 0);
    chk("stream_end_ptr", wr_ptr, 102);
    chk("stream_end_wrap", wrap_count, 2);
    // backpressure for 10 cycles with the source always offering
    for (int c = 0; c < 14; c++) begin
      avm_waitrequest = c < 10; snk_valid = c < 10; snk_data = 32'(32'hA0 + c); #1;
      if (c < 4) chk("bp_ready_hi", snk_ready, 1);
      else if (c < 10) chk("bp_ready_lo", snk_ready, 0);
      chk("bp_ovf", overflow, c >= 5);
      if (c >= 2 && c < 10) begin
        chk("bp_stall_write", avm_write, 1);
        chk("bp_stall_addr", avm_address, 102);
        chk("bp_stall_data", avm_writedata, 32'hA0);
      end
      if (c >= 10) begin
        chk("bp_drain_write", avm_write, 1);
        chk("bp_drain_addr", avm_address, 32'(100 + (c - 8) % 5));
        chk("bp_drain_data", avm_writedata, 32'(32'hA0 + c - 10));
      end
      tick();
    end
    snk_valid = 0; avm_waitrequest = 0; #1;
    chk("bp_end_write", avm_write, 0);
    chk("bp_end_ptr", wr_ptr, 101);
    chk("bp_end_wrap", wrap_count, 3);
    chk("bp_end_ovf", overflow, 1);
    // advance to address 103, then clear during a stalled write there
    snk_valid = 1; snk_data = 32'h11; #1;
    tick();
    snk_data = 32'h22; #1;
    tick();
    snk_valid = 0; #1;
    chk("pre_addr0", avm_address, 101);
    chk("pre_data0", avm_writedata, 32'h11);
    tick();
    chk("pre_addr1", avm_address, 102);
    chk("pre_data1", avm_writedata, 32'h22);
    tick();
    chk("pre_ptr", wr_ptr, 103);
    avm_waitrequest = 1; snk_valid = 1; snk_data = 32'h55; #1;
    tick();
    snk_valid = 0; #1;
    tick();
    chk("cs_write", avm_write, 1);
    chk("cs_addr", avm_address, 103);
    clear = 1; #1;
    tick();
    clear = 0; #1;
    chk("cs_pending_ready", snk_ready, 0);
    chk("cs_hold_addr", avm_address, 103);
    chk("cs_hold_data", avm_writedata, 32'h55);
    chk("cs_hold_ovf", overflow, 1);
    avm_waitrequest = 0; #1;
    chk("cs_done_write", avm_write, 1);
    tick();
    chk("cs_after_write", avm_write, 0);
    chk("cs_after_ptr", wr_ptr, 100);
    chk("cs_after_wrap", wrap_count, 0);
    chk("cs_after_ovf", overflow, 0);
    chk("cs_after_ready", snk_ready, 1);
    snk_valid = 1; snk_data = 32'h77; #1;
    tick();
    snk_valid = 0; #1;
    tick();
    chk("cs_next_write", avm_write, 1);
    chk("cs_next_addr", avm_address, 100);
    chk("cs_next_data", avm_writedata, 32'h77);
    tick();
    chk("cs_next_ptr", wr_ptr, 101);
    // asynchronous reset in the middle of a write
    snk_valid = 1; snk_data = 32'h99; #1;
    tick();
    snk_valid = 0; #1;
    tick();
    chk("ar_write_before", avm_write, 1);
    chk("ar_addr_before", avm_address, 101);
    #2 reset_n = 0;
    #1;
    chk("ar_write", avm_write, 0);
    chk("ar_ptr", wr_ptr, 100);
    chk("ar_addr", avm_address, 100);
    chk("ar_ready", snk_ready, 0);
    tick();
    reset_n = 1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
